// File: rtl/ro_puf_pair_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ro_puf_pair_engine
// Purpose  : Two challenge-configured ring oscillators whose edge counts over a
//            clock window are compared to produce one PUF response bit.
//            Optional `PUF_MARGIN_EN adds the margin_ok reliability flag.
// Revision : 1.0
// ============================================================================
module ro_puf_pair_engine #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 4096,
    parameter int SETTLE = 4,
    parameter int MARGIN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*STAGES-1:0]   challenge,
    output logic                  busy,
    output logic                  done,
    output logic                  response,
    output logic [CNT_W-1:0]      count_a,
    output logic [CNT_W-1:0]      count_b
`ifdef PUF_MARGIN_EN
    ,
    output logic                  margin_ok
`endif
);

    localparam int c_TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_SAMPLE1 = 3'd4,
        ST_SAMPLE2 = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                r_state, w_state_nx;
    logic [c_TMR_W-1:0]    r_tmr, w_tmr_val;
    logic                  w_tmr_ld;
    logic [2*STAGES-1:0]   r_chal;
    logic                  r_ring_en, r_clr;
    logic [CNT_W-1:0]      r_cnt_a, r_cnt_b, r_sync_a, r_sync_b;
    logic [CNT_W-1:0]      r_count_a, r_count_b;
    logic                  r_response;
    logic                  w_cnt_rst_n;

    // ---------------- ring oscillators ----------------
    (* dont_touch = "true" *) logic [STAGES:0] w_node_a, w_node_b;
    (* dont_touch = "true" *) logic            w_ring_a, w_ring_b;

    assign w_node_a[0] = r_ring_en & w_ring_a;
    assign w_node_b[0] = r_ring_en & w_ring_b;
    assign w_ring_a    = w_node_a[STAGES];
    assign w_ring_b    = w_node_b[STAGES];

    // Each stage has two independent inverting paths; the challenge bit picks one,
    // so the stage always inverts but its delay depends on the chosen path.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        (* dont_touch = "true" *) logic w_inv0_a, w_inv1_a, w_inv0_b, w_inv1_b;
        assign w_inv0_a      = ~w_node_a[i];
        assign w_inv1_a      = ~w_node_a[i];
        assign w_inv0_b      = ~w_node_b[i];
        assign w_inv1_b      = ~w_node_b[i];
        assign w_node_a[i+1] = r_chal[i]          ? w_inv1_a : w_inv0_a;
        assign w_node_b[i+1] = r_chal[STAGES + i] ? w_inv1_b : w_inv0_b;
    end

    // Ring-clocked saturating counters, cleared asynchronously by reset or CLEAR.
    assign w_cnt_rst_n = rst_n & ~r_clr;

    always_ff @(posedge w_ring_a or negedge w_cnt_rst_n) begin
        if (!w_cnt_rst_n)                r_cnt_a <= '0;
        else if (r_cnt_a != {CNT_W{1'b1}}) r_cnt_a <= r_cnt_a + 1'b1;
    end

    always_ff @(posedge w_ring_b or negedge w_cnt_rst_n) begin
        if (!w_cnt_rst_n)                r_cnt_b <= '0;
        else if (r_cnt_b != {CNT_W{1'b1}}) r_cnt_b <= r_cnt_b + 1'b1;
    end

    // ---------------- control FSM ----------------
    always_comb begin
        w_state_nx = r_state;
        w_tmr_ld   = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE:    if (start) w_state_nx = ST_CLEAR;
            ST_CLEAR: begin
                w_state_nx = ST_RUN;
                w_tmr_ld   = 1'b1;
                w_tmr_val  = c_TMR_W'(WINDOW - 1);
            end
            ST_RUN: if (r_tmr == '0) begin
                w_state_nx = ST_SETTLE;
                w_tmr_ld   = 1'b1;
                w_tmr_val  = c_TMR_W'(SETTLE - 1);
            end
            ST_SETTLE:  if (r_tmr == '0) w_state_nx = ST_SAMPLE1;
            ST_SAMPLE1: w_state_nx = ST_SAMPLE2;
            ST_SAMPLE2: w_state_nx = ST_DONE;
            ST_DONE:    w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tmr     <= '0;
            r_chal    <= '0;
            r_ring_en <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            if (w_tmr_ld)          r_tmr <= w_tmr_val;
            else if (r_tmr != '0)  r_tmr <= r_tmr - 1'b1;
            if (r_state == ST_IDLE && start) r_chal <= challenge;
            // Registered decodes keep the ring enable and async clear glitch-free.
            r_ring_en <= (w_state_nx == ST_RUN);
            r_clr     <= (w_state_nx == ST_CLEAR);
        end
    end

`ifdef PUF_MARGIN_EN
    logic [CNT_W:0] w_diff, w_absdiff;
    logic           r_margin_ok;
    assign w_diff    = {1'b0, r_sync_a} - {1'b0, r_sync_b};
    assign w_absdiff = w_diff[CNT_W] ? (~w_diff + 1'b1) : w_diff;
    assign margin_ok = r_margin_ok;
`endif

    // Counters are static by SAMPLE; two CLK-domain stages bring them across.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a    <= '0;
            r_sync_b    <= '0;
            r_count_a   <= '0;
            r_count_b   <= '0;
            r_response  <= 1'b0;
`ifdef PUF_MARGIN_EN
            r_margin_ok <= 1'b0;
`endif
        end else begin
            if (r_state == ST_SAMPLE1) begin
                r_sync_a <= r_cnt_a;
                r_sync_b <= r_cnt_b;
            end
            if (r_state == ST_SAMPLE2) begin
                r_count_a   <= r_sync_a;
                r_count_b   <= r_sync_b;
                r_response  <= (r_sync_a > r_sync_b);
`ifdef PUF_MARGIN_EN
                r_margin_ok <= (r_sync_a != r_sync_b) &&
                               (w_absdiff >= (CNT_W+1)'(MARGIN));
`endif
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign response = r_response;
    assign count_a  = r_count_a;
    assign count_b  = r_count_b;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_pair_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ro_puf_pair_engine
// Purpose  : Directed bench; behavioural ring models drive the ring nodes.
// Revision : 1.0
// ============================================================================
module tb_ro_puf_pair_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [9:0]  ch0 = '0, ch1 = '0;
    logic        busy0, done0, resp0, busy1, done1, resp1;
    logic [15:0] cnta0, cntb0;
    logic [3:0]  cnta1, cntb1;
`ifdef PUF_MARGIN_EN
    logic        mok0, mok1;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat;
    int          n_done;
    logic [3:0]  rq = '0;
    logic [9:0]  chal_lat [2];
    real         hp_ovr [4];
    wire  [1:0]  env;

    always #5 clk = ~clk;

    ro_puf_pair_engine #(.STAGES(5), .CNT_W(16), .WINDOW(64), .SETTLE(4), .MARGIN(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .challenge(ch0),
        .busy(busy0), .done(done0), .response(resp0), .count_a(cnta0), .count_b(cntb0)
`ifdef PUF_MARGIN_EN
        , .margin_ok(mok0)
`endif
    );

    ro_puf_pair_engine #(.STAGES(5), .CNT_W(4), .WINDOW(64), .SETTLE(4), .MARGIN(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .challenge(ch1),
        .busy(busy1), .done(done1), .response(resp1), .count_a(cnta1), .count_b(cntb1)
`ifdef PUF_MARGIN_EN
        , .margin_ok(mok1)
`endif
    );

    assign env = {dut1.r_ring_en, dut0.r_ring_en};

    initial begin
        force dut0.w_ring_a = rq[0];
        force dut0.w_ring_b = rq[1];
        force dut1.w_ring_a = rq[2];
        force dut1.w_ring_b = rq[3];
    end

    // Stage delay 1.0 ns on path 0, 1.2 ns on path 1; half period = sum of stages.
    function automatic real half_period(input int idx);
        logic [9:0] c;
        logic [4:0] sel;
        real        s;
        if (hp_ovr[idx] > 0.0) return hp_ovr[idx];
        c   = chal_lat[idx/2];
        sel = (idx % 2 == 1) ? c[9:5] : c[4:0];
        s   = 0.0;
        for (int i = 0; i < 5; i++) s += sel[i] ? 1.2 : 1.0;
        return s;
    endfunction

    task automatic ring_model(input int idx);
        real hp;
        forever begin
            wait (env[idx/2] === 1'b1);
            hp = half_period(idx);
            while (env[idx/2] === 1'b1) begin
                #(hp);
                if (env[idx/2] === 1'b1) rq[idx] = ~rq[idx];
            end
            rq[idx] = 1'b0;
        end
    endtask

    initial fork
        ring_model(0);
        ring_model(1);
        ring_model(2);
        ring_model(3);
    join_none

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns edges from acceptance to the DONE cycle, -1 on timeout.
    task automatic measure(input int inst, input logic [9:0] ch, input bit poke, output int l);
        l = -1;
        chal_lat[inst] = ch;
        if (inst == 0) begin ch0 = ch; start0 = 1'b1; end
        else           begin ch1 = ch; start1 = 1'b1; end
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 0) begin
                start0 = 1'b0; start1 = 1'b0;
                chk("busy_after_start", (inst == 0) ? busy0 : busy1, 1);
            end
            if (poke && n == 10) begin start0 = 1'b1; ch0 = ~ch; end
            if (poke && n == 11) start0 = 1'b0;
            if (((inst == 0) ? done0 : done1) === 1'b1) begin l = n; break; end
        end
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done0 === 1'b1) nd++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) hp_ovr[i] = 0.0;
        chal_lat[0] = '0;
        chal_lat[1] = '0;

        // Reset with ring nodes toggling: counters must stay cleared.
        for (int i = 0; i < 6; i++) begin #3; rq = ~rq; end
        #3 rq = '0;
        @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_resp", resp0, 0);
        chk("rst_cnt_a_out", cnta0, 0);
        chk("rst_cnt_b_out", cntb0, 0);
        chk("rst_ring_cnt_a", dut0.r_cnt_a, 0);
        chk("rst_ring_cnt_b1", dut1.r_cnt_b, 0);
`ifdef PUF_MARGIN_EN
        chk("rst_margin_ok", mok0, 0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy0, 0);

        // Ring A faster: A half period 5 ns (64 rises), B 6 ns (53 rises).
        measure(0, 10'b11111_00000, 1'b0, lat);
        chk("basic_latency", lat, 71);
        chk("basic_resp", resp0, 1);
        chk("basic_cnt_a", cnta0, 64);
        chk("basic_cnt_b", cntb0, 53);
`ifdef PUF_MARGIN_EN
        chk("basic_margin_ok", mok0, 1);
`endif
        @(negedge clk);
        chk("done_one_cycle", done0, 0);
        chk("busy_falls", busy0, 0);

        // Swapped challenge, with START and a challenge change mid-measurement.
        measure(0, 10'b00000_11111, 1'b1, lat);
        chk("swap_latency", lat, 71);
        chk("swap_resp", resp0, 0);
        chk("swap_cnt_a", cnta0, 53);
        chk("swap_cnt_b", cntb0, 64);
        count_done(90, n_done);
        chk("no_second_done", n_done, 0);
        chk("swap_cnt_a_hold", cnta0, 53);
        chk("swap_resp_hold", resp0, 0);

        // Reset pulse in RUN cycle 20.
        chal_lat[0] = 10'b11111_00000;
        ch0 = 10'b11111_00000;
        start0 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); @(negedge clk);
            start0 = 1'b0;
        end
        chk("mid_run_ring_en", dut0.r_ring_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_ring_en", dut0.r_ring_en, 0);
        chk("mid_rst_cnt_a", dut0.r_cnt_a, 0);
        chk("mid_rst_cnt_b", dut0.r_cnt_b, 0);
        chk("mid_rst_count_a_out", cnta0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(90, n_done);
        chk("mid_rst_no_done", n_done, 0);
        measure(0, 10'b11111_00000, 1'b0, lat);
        chk("post_rst_latency", lat, 71);
        chk("post_rst_resp", resp0, 1);
        chk("post_rst_cnt_a", cnta0, 64);
        chk("post_rst_cnt_b", cntb0, 53);

        // 4-bit counters saturate on both rings: tie.
        measure(1, 10'b11111_00000, 1'b0, lat);
        chk("sat_latency", lat, 71);
        chk("sat_cnt_a", cnta1, 15);
        chk("sat_cnt_b", cntb1, 15);
        chk("sat_resp", resp1, 0);
`ifdef PUF_MARGIN_EN
        chk("sat_margin_ok", mok1, 0);

        // Margin threshold: B half period 5.6 ns -> 57 rises, 5.7 ns -> 56 rises.
        @(negedge clk);
        hp_ovr[1] = 5.6;
        measure(0, 10'b00000_00000, 1'b0, lat);
        chk("margin7_cnt_b", cntb0, 57);
        chk("margin7_ok", mok0, 0);
        chk("margin7_resp", resp0, 1);
        @(negedge clk);
        hp_ovr[1] = 5.7;
        measure(0, 10'b00000_00000, 1'b0, lat);
        chk("margin8_cnt_b", cntb0, 56);
        chk("margin8_ok", mok0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
